// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the fetch stage and
// the data stage of the pipelined core. One requester is granted at a time.
// The memory transaction is held until mem_ack. The winner then receives its
// read data and a one-cycle ready pulse.
// Optional build macro ARB_FAIR_EN: after MAXD consecutive data grants made
// while a fetch is waiting, the fetch is forced through. When the macro is
// undefined, data always has priority and no counter exists.
module mem_port_arbiter #(
    parameter int AW   = 32,
    parameter int DW   = 32,
    parameter int MAXD = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ready,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ready,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          stall
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        D_BUSY  = 2'd2,
        RESP    = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          if_ready_q, if_ready_d;
    logic          d_ready_q, d_ready_d;
    logic          fetch_first;

`ifdef ARB_FAIR_EN
    // The counter is at least 3 bits wide, and wide enough to hold MAXD.
    localparam int CW = ($clog2(MAXD + 1) > 3) ? $clog2(MAXD + 1) : 3;
    localparam logic [CW-1:0] MAXD_C = CW'(MAXD);

    logic [CW-1:0] fair_cnt_q, fair_cnt_d;

    // The starved fetch overrides data priority once its quota is used up.
    assign fetch_first = if_req && d_req && (fair_cnt_q == MAXD_C);
`else
    assign fetch_first = 1'b0;
`endif

    // A requester stalls the pipe until its ready pulse arrives.
    assign stall = (if_req & ~if_ready_q) | (d_req & ~d_ready_q);

    // Next-state logic: arbitration, the hold-until-ack rule, and response capture.
    always_comb begin
        // NOTE: every variable gets a default here first. A path that leaves
        // any variable unassigned would infer a latch.
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_ready_d  = 1'b0;
        d_ready_d   = 1'b0;
`ifdef ARB_FAIR_EN
        fair_cnt_d  = fair_cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (d_req && !fetch_first) begin
                    state_d     = D_BUSY;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
`ifdef ARB_FAIR_EN
                    if (if_req && (fair_cnt_q != MAXD_C)) begin
                        fair_cnt_d = fair_cnt_q + CW'(1);
                    end
`endif
                end else if (if_req) begin
                    state_d    = IF_BUSY;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = if_addr;
`ifdef ARB_FAIR_EN
                    fair_cnt_d = '0;
`endif
                end
            end
            IF_BUSY: begin
                if (mem_ack) begin
                    if_rdata_d = mem_rdata;
                    if_ready_d = 1'b1;
                    mem_req_d  = 1'b0;
                    mem_we_d   = 1'b0;
                    state_d    = RESP;
                end
            end
            D_BUSY: begin
                if (mem_ack) begin
                    // A store leaves the previous load data visible.
                    if (!mem_we_q) begin
                        d_rdata_d = mem_rdata;
                    end
                    d_ready_d = 1'b1;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    state_d   = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs. Asynchronous reset clears everything at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_ready_q  <= 1'b0;
            d_ready_q   <= 1'b0;
        end else begin
            // NOTE: use non-blocking assignments so that every register samples
            // the values from before the edge. This keeps results independent
            // of statement order.
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_ready_q  <= if_ready_d;
            d_ready_q   <= d_ready_d;
        end
    end

`ifdef ARB_FAIR_EN
    // Fairness counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fair_cnt_q <= '0;
        end else begin
            fair_cnt_q <= fair_cnt_d;
        end
    end
`endif

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign if_ready  = if_ready_q;
    assign d_ready   = d_ready_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one unified single-port memory between two requesters: the instruction-fetch stage and the data-memory stage of the pipelined mips core.
- Grants one requester at a time and holds the memory transaction until the memory acknowledges.
- Returns read data and a one-cycle ready pulse to the granted requester.
- Drives a pipeline stall while any request is outstanding, so the core can freeze the IF/ID and later pipe registers.

Parameters:
- AW, 32, address width in bits.
- DW, 32, data width in bits.
- MAXD, 4, consecutive data grants allowed while a fetch waits. Used only with ARB_FAIR_EN.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  asynchronous active-low reset (asserted when 0)
- if_req  in  1  fetch request, level; held until if_ready
- if_addr  in  AW  fetch address; stable while if_req=1
- if_rdata  out  DW  fetched instruction; valid while if_ready=1
- if_ready  out  1  one-cycle completion pulse for fetch
- d_req  in  1  data request, level; held until d_ready
- d_we  in  1  1=store, 0=load; stable while d_req=1
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_rdata  out  DW  load data; valid while d_ready=1
- d_ready  out  1  one-cycle completion pulse for data
- mem_req  out  1  memory transaction request, registered
- mem_we  out  1  memory write enable, registered
- mem_addr  out  AW  memory address, registered
- mem_wdata  out  DW  memory write data, registered
- mem_rdata  in  DW  memory read data; valid with mem_ack
- mem_ack  in  1  memory completion, one cycle, only while mem_req=1
- stall  out  1  combinational: (if_req&~if_ready)|(d_req&~d_ready)

Behaviour:
- States: IDLE, IF_BUSY, D_BUSY, RESP.
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - if_ready=0, d_ready=0, if_rdata=0, d_rdata=0.
  - Fairness counter=0.
- IDLE:
  - d_req=1: go to D_BUSY; load mem_addr=d_addr, mem_we=d_we, mem_wdata=d_wdata; mem_req=1 next cycle. Data has fixed priority.
  - else if_req=1: go to IF_BUSY; mem_addr=if_addr, mem_we=0, mem_req=1.
  - else stay in IDLE.
- IF_BUSY / D_BUSY:
  - Hold mem_* outputs constant until mem_ack=1.
  - On mem_ack:
    - capture mem_rdata into if_rdata or d_rdata. For stores, d_rdata keeps its previous value.
    - mem_req=0, mem_we=0.
    - assert the matching ready for exactly one cycle.
    - go to RESP.
- RESP: ready pulse cycle; no new grant; go to IDLE.
- Requester handshake: the requester must drop req in the cycle after it sees ready. A req still high in IDLE is treated as a new request.
- Latency:
  - req at cycle T with state IDLE: mem_req at T+1.
  - mem_ack at T+1+k (k≥0): ready at T+2+k.
  - Next grant is possible at T+3+k.
- Simultaneous if_req and d_req in IDLE: data is granted. The fetch waits with stall=1.
- mem_ack in IDLE or RESP: ignored.
- Request inputs changing mid-transaction: no effect. Outputs were latched at grant.
- Reset mid-transaction:
  - all outputs return to reset values immediately.
  - A mem_ack arriving after reset is released is ignored.
- stall=1 on any cycle with an unserved request, including the arbitration cycle. stall=0 on the ready cycle.

Optional Feature:
- Macro: ARB_FAIR_EN.
- Defined:
  - A 3-bit-or-wider counter increments on each data grant made while if_req=1.
  - The counter clears on any fetch grant.
  - When counter==MAXD and both requests are pending in IDLE, the fetch is granted.
- Not defined: strict data priority; no counter logic is synthesized.

Test Plan:
- Single fetch:
  - Stimulus: if_req=1, if_addr=0x00000040; memory acks 2 cycles after mem_req.
  - Required: mem_req=1 with mem_addr=0x40 and mem_we=0 for 3 cycles; if_ready pulses once with if_rdata=mem_rdata (e.g. 0x20080005); stall=1 until that cycle.
- Store then load:
  - Stimulus: d_req with d_we=1, d_addr=0x54, d_wdata=0x7; then a load from 0x54 returning 0x7.
  - Required: mem_we=1 only during the store; d_rdata=0x7 on the second d_ready.
- Contention:
  - Stimulus: if_req and d_req raised in the same cycle; memory acks immediately.
  - Required: data granted first (d_ready at T+2); fetch mem_req at T+4; if_ready at T+5.
- Reset mid-transaction:
  - Stimulus: pull reset=0 while in D_BUSY, before mem_ack.
  - Required: mem_req=0 and d_ready=0 asynchronously; after release with no requests, state stays IDLE and a late mem_ack is ignored.
- Fairness (ARB_FAIR_EN, MAXD=4):
  - Stimulus: d_req held continuously (re-raised each cycle after ready) with if_req=1.
  - Required: exactly 4 data grants, then the fetch is granted. Without the macro, the fetch is never granted.
